// File: rtl/axis_traffic_gen_if.sv
// AXI4-Stream bundle for the traffic generator.
// Handshake: a beat transfers when tvalid && tready at a clock posedge; once tvalid
// is high, tdata/tdest/tid/tlast hold and tvalid stays high until that transfer.
interface axis_traffic_gen_if #(
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 4,
    parameter int ID_WIDTH   = 4
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [DEST_WIDTH-1:0] tdest;
    logic [ID_WIDTH-1:0]   tid;
    logic                  tlast;

    modport master (output tvalid, tdata, tdest, tid, tlast, input tready);
    modport slave  (input tvalid, tdata, tdest, tid, tlast, output tready);
endinterface

// File: rtl/axis_traffic_gen.sv
// AXI4-Stream master traffic generator: runtime length, TLAST every N beats,
// inter-packet idle gap, increment or LFSR payload, and graceful abort.
module axis_traffic_gen #(
    parameter int          DATA_WIDTH = 64,
    parameter int          DEST_WIDTH = 4,
    parameter int          ID_WIDTH   = 4,
    parameter int          ID         = 0,
    parameter int          LEN_WIDTH  = 16,
    parameter int          GAP_WIDTH  = 4,
    parameter logic [63:0] BASE_DATA  = 64'hdeadbeef00000000,
    parameter logic [63:0] LFSR_TAPS  = 64'hd800000000000000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start,
    input  logic [DEST_WIDTH-1:0] cfg_dest,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [LEN_WIDTH-1:0]  cfg_burst,
    input  logic [GAP_WIDTH-1:0]  cfg_gap,
    input  logic                  cfg_mode,
    input  logic                  abort,
    axis_traffic_gen_if.master    axis,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  beats_sent,
    output logic [1:0]            o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] P_BASE = BASE_DATA[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] P_TAPS = LFSR_TAPS[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] D_ONE  = DATA_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  L_ONE  = LEN_WIDTH'(1);
    localparam logic [GAP_WIDTH-1:0]  G_ONE  = GAP_WIDTH'(1);

    state_t                r_state, w_state_nxt;
    logic [DEST_WIDTH-1:0] r_dest;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_burst;
    logic [GAP_WIDTH-1:0]  r_gap;
    logic                  r_mode;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic [LEN_WIDTH-1:0]  r_beats;
    logic [LEN_WIDTH-1:0]  r_pkt;
    logic [GAP_WIDTH-1:0]  r_gap_cnt;
    logic                  r_abort_pend;
    logic                  r_done;

    logic                  w_start_go;
    logic                  w_hs;
    logic                  w_abort_eff;
    logic                  w_final;
    logic                  w_end;
    logic                  w_to_gap;
    logic                  w_gap_done;
    logic [LEN_WIDTH-1:0]  w_burst_in;
    logic                  w_tlast_first;
    logic [LEN_WIDTH-1:0]  w_pkt_nxt;
    logic [LEN_WIDTH-1:0]  w_beats_nxt;
    logic                  w_tlast_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic [DATA_WIDTH-1:0] w_seed;

    always_comb begin
        w_start_go    = start && (cfg_len != '0);
        w_hs          = r_tvalid && axis.tready;
        w_abort_eff   = r_abort_pend || abort;
        w_final       = (r_beats == (r_len - L_ONE));
        // A pending abort ends the transfer on the first TLAST beat that completes.
        w_end         = w_hs && (w_final || (r_tlast && w_abort_eff));
        w_to_gap      = w_hs && !w_end && r_tlast && (r_gap != '0);
        w_gap_done    = (r_gap_cnt == G_ONE);
        w_burst_in    = (cfg_burst == '0) ? L_ONE : cfg_burst;
        w_tlast_first = (w_burst_in == L_ONE) || (cfg_len == L_ONE);
        w_pkt_nxt     = r_tlast ? '0 : (r_pkt + L_ONE);
        w_beats_nxt   = r_beats + L_ONE;
        w_tlast_nxt   = (w_pkt_nxt == (r_burst - L_ONE)) ||
                        (w_beats_nxt == (r_len - L_ONE)) || w_abort_eff;
        w_data_nxt    = r_mode ? {r_tdata[DATA_WIDTH-2:0], ^(r_tdata & P_TAPS)}
                               : (r_tdata + D_ONE);
        // An all-zero LFSR would lock up, so a zero seed starts at 1.
        w_seed        = (cfg_mode && (P_BASE == '0)) ? D_ONE : P_BASE;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start_go) w_state_nxt = S_SEND;
            S_SEND: begin
                if (w_end)         w_state_nxt = S_IDLE;
                else if (w_to_gap) w_state_nxt = S_GAP;
            end
            S_GAP: begin
                if (abort)           w_state_nxt = S_IDLE;
                else if (w_gap_done) w_state_nxt = S_SEND;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_dest       <= '0;
            r_len        <= '0;
            r_burst      <= L_ONE;
            r_gap        <= '0;
            r_mode       <= 1'b0;
            r_tdata      <= P_BASE;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_beats      <= '0;
            r_pkt        <= '0;
            r_gap_cnt    <= '0;
            r_abort_pend <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_go) begin
                        r_dest       <= cfg_dest;
                        r_len        <= cfg_len;
                        r_burst      <= w_burst_in;
                        r_gap        <= cfg_gap;
                        r_mode       <= cfg_mode;
                        r_tdata      <= w_seed;
                        r_tvalid     <= 1'b1;
                        r_tlast      <= w_tlast_first;
                        r_beats      <= '0;
                        r_pkt        <= '0;
                        r_abort_pend <= 1'b0;
                    end else if (start) begin
                        r_done <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_hs) begin
                        r_beats <= w_beats_nxt;
                        r_tdata <= w_data_nxt;
                        if (w_end) begin
                            r_tvalid     <= 1'b0;
                            r_tlast      <= 1'b0;
                            r_abort_pend <= 1'b0;
                            r_done       <= 1'b1;
                        end else begin
                            r_tlast      <= w_tlast_nxt;
                            r_pkt        <= w_pkt_nxt;
                            r_abort_pend <= w_abort_eff;
                            if (w_to_gap) begin
                                r_tvalid  <= 1'b0;
                                r_gap_cnt <= r_gap;
                            end
                        end
                    end else if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        r_done <= 1'b1;
                    end else if (w_gap_done) begin
                        r_tvalid <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - G_ONE;
                    end
                end
                default: r_tvalid <= 1'b0;
            endcase
        end
    end

    assign axis.tvalid = r_tvalid;
    assign axis.tdata  = r_tdata;
    assign axis.tdest  = r_dest;
    assign axis.tid    = ID_WIDTH'(ID);
    assign axis.tlast  = r_tlast;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign beats_sent  = r_beats;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_axis_traffic_gen.sv
// Bench for axis_traffic_gen: a 64-bit increment instance and an 8-bit LFSR instance
// share the config inputs; outputs are sampled on the falling edge.
module tb_axis_traffic_gen;
  localparam logic [63:0] BASE64 = 64'hdeadbeef00000000;

  // clock / reset
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic        start = 1'b0;
  logic [3:0]  cfg_dest = '0;
  logic [15:0] cfg_len = '0;
  logic [15:0] cfg_burst = '0;
  logic [3:0]  cfg_gap = '0;
  logic        cfg_mode = 1'b0;
  logic        abort = 1'b0;
  logic        tready = 1'b0;
  logic        sel = 1'b0;

  axis_traffic_gen_if #(.DATA_WIDTH(64), .DEST_WIDTH(4), .ID_WIDTH(4)) if0 ();
  axis_traffic_gen_if #(.DATA_WIDTH(8), .DEST_WIDTH(4), .ID_WIDTH(4)) if1 ();
  assign if0.tready = tready;
  assign if1.tready = tready;

  logic        busy0, done0, busy1, done1;
  logic [15:0] beats0, beats1;
  logic [1:0]  st0, st1;

  axis_traffic_gen dut0 (
    .CLK(CLK), .RST_N(RST_N), .start(start && !sel), .cfg_dest(cfg_dest),
    .cfg_len(cfg_len), .cfg_burst(cfg_burst), .cfg_gap(cfg_gap), .cfg_mode(cfg_mode),
    .abort(abort && !sel), .axis(if0), .busy(busy0), .done(done0),
    .beats_sent(beats0), .o_dbg_state(st0)
  );

  axis_traffic_gen #(.DATA_WIDTH(8), .BASE_DATA(64'h1), .LFSR_TAPS(64'hb8)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .start(start && sel), .cfg_dest(cfg_dest),
    .cfg_len(cfg_len), .cfg_burst(cfg_burst), .cfg_gap(cfg_gap), .cfg_mode(cfg_mode),
    .abort(abort && sel), .axis(if1), .busy(busy1), .done(done1),
    .beats_sent(beats1), .o_dbg_state(st1)
  );

  logic [63:0] m_data;
  logic [3:0]  m_dest, m_tid;
  logic        m_valid, m_last, m_busy, m_done;
  logic [15:0] m_beats;
  always_comb begin
    m_data  = sel ? 64'(if1.tdata) : if0.tdata;
    m_dest  = sel ? if1.tdest : if0.tdest;
    m_tid   = sel ? if1.tid : if0.tid;
    m_valid = sel ? if1.tvalid : if0.tvalid;
    m_last  = sel ? if1.tlast : if0.tlast;
    m_busy  = sel ? busy1 : busy0;
    m_done  = sel ? done1 : done0;
    m_beats = sel ? beats1 : beats0;
  end

  // scoreboard
  logic [63:0] exp_q[$];
  logic        exp_last_q[$];
  logic [3:0]  exp_dest;
  int          exp_gap;
  int          n_checks = 0;
  int          n_errors = 0;

  logic        p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
  logic [63:0] p_data = '0;
  logic [3:0]  p_dest = '0;
  logic        gap_wait = 1'b0;
  int          gap_obs = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_incr(input int len, input int burst);
    int b;
    b = (burst == 0) ? 1 : burst;
    for (int k = 0; k < len; k++) begin
      exp_q.push_back(BASE64 + 64'(k));
      exp_last_q.push_back(((k % b) == b - 1) || (k == len - 1));
    end
  endtask

  task automatic push_lfsr(input int n, input logic [7:0] seed, input int last_at);
    logic [7:0] d;
    d = seed;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(64'(d));
      exp_last_q.push_back(k == last_at);
      d = {d[6:0], ^(d & 8'hb8)};
    end
  endtask

  task automatic start_xfer(input int len, input int burst, input int gap,
                            input logic mode, input logic [3:0] dest);
    @(negedge CLK);
    cfg_len   = 16'(len);
    cfg_burst = 16'(burst);
    cfg_gap   = 4'(gap);
    cfg_mode  = mode;
    cfg_dest  = dest;
    exp_dest  = dest;
    exp_gap   = gap;
    start     = 1'b1;
  endtask

  // rmode: 0 = tready high, 1 = random, 2 = tready low
  task automatic step(input int rmode, input logic ab);
    @(negedge CLK);
    start = 1'b0;
    abort = ab;
    if (p_valid && !p_ready) begin
      check("stall_data", m_data, p_data);
      check("stall_ctl", 64'({m_valid, m_last, m_dest}), 64'({1'b1, p_last, p_dest}));
    end
    if (gap_wait) begin
      if (!m_valid) gap_obs++;
      else begin
        check("gap_len", 64'(gap_obs), 64'(exp_gap));
        gap_wait = 1'b0;
      end
    end
    tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (m_valid && tready) begin
      if (exp_q.size() == 0) check("extra_beat", 64'(1), 64'(0));
      else begin
        check("tdata", m_data, exp_q.pop_front());
        check("tlast", 64'(m_last), 64'(exp_last_q.pop_front()));
        check("tdest", 64'(m_dest), 64'(exp_dest));
        if (m_last && exp_q.size() != 0) begin
          gap_wait = 1'b1;
          gap_obs  = 0;
        end
      end
    end
    p_valid = m_valid;
    p_ready = tready;
    p_data  = m_data;
    p_last  = m_last;
    p_dest  = m_dest;
  endtask

  task automatic run_q(input int rmode, input int exp_beats);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 2000) begin
      step(rmode, 1'b0);
      if (budget == 0) check("busy_active", 64'(m_busy), 64'(1));
      budget++;
    end
    if (exp_q.size() != 0) begin
      check("timeout_left", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
      exp_last_q.delete();
    end
    step(0, 1'b0);
    check("done_pulse", 64'(m_done), 64'(1));
    check("valid_after", 64'(m_valid), 64'(0));
    step(0, 1'b0);
    check("done_single", 64'(m_done), 64'(0));
    check("busy_after", 64'(m_busy), 64'(0));
    check("beats_sent", 64'(m_beats), 64'(exp_beats));
  endtask

  initial begin
    #12;
    check("rst_valid", 64'(m_valid), 64'(0));
    check("rst_last", 64'(m_last), 64'(0));
    check("rst_busy", 64'(m_busy), 64'(0));
    check("rst_done", 64'(m_done), 64'(0));
    check("rst_data", m_data, BASE64);
    check("rst_dest", 64'(m_dest), 64'(0));
    check("rst_tid", 64'(m_tid), 64'(0));
    check("rst_beats", 64'(m_beats), 64'(0));
    @(negedge CLK);
    RST_N = 1'b1;

    // single 24-beat packet, full throughput
    start_xfer(24, 24, 0, 1'b0, 4'd2);
    push_incr(24, 24);
    run_q(0, 24);

    // same with random back-pressure
    start_xfer(24, 24, 0, 1'b0, 4'd2);
    push_incr(24, 24);
    run_q(1, 24);

    // three packets of 8 with 3-cycle gaps
    start_xfer(24, 8, 3, 1'b0, 4'd5);
    push_incr(24, 8);
    run_q(1, 24);

    // zero length: done only
    start_xfer(0, 4, 0, 1'b0, 4'd3);
    step(0, 1'b0);
    check("len0_done", 64'(m_done), 64'(1));
    check("len0_valid", 64'(m_valid), 64'(0));
    step(0, 1'b0);
    check("len0_done_single", 64'(m_done), 64'(0));
    check("len0_valid2", 64'(m_valid), 64'(0));

    // burst 0 behaves as 1: tlast every beat
    start_xfer(3, 0, 0, 1'b0, 4'd1);
    push_incr(3, 1);
    run_q(1, 3);

    // reset while beat 5 is presented
    start_xfer(24, 24, 0, 1'b0, 4'd2);
    push_incr(24, 24);
    for (int i = 0; i < 100 && exp_q.size() > 19; i++) step(0, 1'b0);
    check("pre_reset_valid", 64'(m_valid), 64'(1));
    #2;
    RST_N = 1'b0;
    #1;
    check("mid_rst_valid", 64'(m_valid), 64'(0));
    check("mid_rst_beats", 64'(m_beats), 64'(0));
    check("mid_rst_data", m_data, BASE64);
    @(negedge CLK);
    check("mid_rst_done", 64'(m_done), 64'(0));
    exp_q.delete();
    exp_last_q.delete();
    gap_wait = 1'b0;
    p_valid  = 1'b0;
    RST_N    = 1'b1;
    start_xfer(24, 24, 0, 1'b0, 4'd2);
    push_incr(24, 24);
    run_q(1, 24);

    // 8-bit LFSR instance
    sel = 1'b1;
    p_valid = 1'b0;
    start_xfer(4, 4, 0, 1'b1, 4'd7);
    push_lfsr(4, 8'h01, 3);
    run_q(1, 4);

    // abort while stalled on beat 2 of a 10-beat packet
    start_xfer(10, 10, 0, 1'b1, 4'd6);
    push_lfsr(4, 8'h01, 3);
    for (int i = 0; i < 100 && exp_q.size() > 2; i++) step(0, 1'b0);
    step(2, 1'b1);
    run_q(0, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
